// File: rtl/seg_pkg.sv
// Shared types and segment constants for the 2-digit 7-segment scan driver.
// Segment encodings are active-high, bit0 = a ... bit6 = g.
package seg_pkg;

  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_GAP_LH = 2'd1,
    S_HI     = 2'd2,
    S_GAP_HL = 2'd3
  } scan_state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Scan order: units, gap, tens, gap, then wrap.
  function automatic scan_state_e next_state(input scan_state_e s);
    case (s)
      S_LO:     next_state = S_GAP_LH;
      S_GAP_LH: next_state = S_HI;
      S_HI:     next_state = S_GAP_HL;
      S_GAP_HL: next_state = S_LO;
      default:  next_state = S_GAP_HL;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-high 7-segment decoder.
// Non-decimal codes (A-F) show a dash so a corrupted count is visible.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit lookup
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed 7-segment driver with blanking gaps and per-frame input snapshot.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GAP_CYC  = 16,
  parameter bit          SEG_POL  = 1'b0,
  parameter bit          DIG_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] qh,
  input  logic [3:0] ql,
  input  logic       en,
  output logic [6:0] seg,
  output logic [1:0] dig,
  output logic       frame_start
);

  localparam int unsigned MAX_DIV = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int unsigned PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYC - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [6:0]    SEG_OFF   = {7{SEG_POL}};
  localparam logic [1:0]    DIG_OFF   = {2{DIG_POL}};

  scan_state_e   state_r;
  logic [PW-1:0] presc_r;
  logic [3:0]    shadow_h_r;
  logic [3:0]    shadow_l_r;
  logic          frame_start_r;
  logic [6:0]    seg_r;
  logic [1:0]    dig_r;

  logic          last_s;
  logic          lz_blank_s;
  logic [3:0]    dec_in_s;
  logic [6:0]    dec_out_s;
  logic [6:0]    seg_act_s;
  logic [1:0]    dig_act_s;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign lz_blank_s = (shadow_h_r == 4'd0);
`else
  assign lz_blank_s = 1'b0;
`endif

  // Dwell end: digit phases use SCAN_DIV, gaps use GAP_CYC
  always_comb begin
    if ((state_r == S_LO) || (state_r == S_HI)) begin
      last_s = (presc_r == SCAN_LAST);
    end else begin
      last_s = (presc_r == GAP_LAST);
    end
  end

  // Single decoder shared by both digits
  always_comb begin
    if (state_r == S_HI) begin
      dec_in_s = shadow_h_r;
    end else begin
      dec_in_s = shadow_l_r;
    end
  end

  bcd_to_seg u_dec (
    .bcd (dec_in_s),
    .seg (dec_out_s)
  );

  // Active-high output selection from the current state and shadows
  always_comb begin
    seg_act_s = SEG_BLANK;
    dig_act_s = 2'b00;
    case (state_r)
      S_LO: begin
        if (en) begin
          seg_act_s = dec_out_s;
          dig_act_s = 2'b01;
        end else begin
          seg_act_s = SEG_BLANK;
          dig_act_s = 2'b00;
        end
      end
      S_HI: begin
        if (en && !lz_blank_s) begin
          seg_act_s = dec_out_s;
          dig_act_s = 2'b10;
        end else begin
          seg_act_s = SEG_BLANK;
          dig_act_s = 2'b00;
        end
      end
      default: begin
        seg_act_s = SEG_BLANK;
        dig_act_s = 2'b00;
      end
    endcase
  end

  // Scan FSM, prescaler and frame snapshot; disable parks at the start of the pre-frame gap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_GAP_HL;
      presc_r       <= '0;
      shadow_h_r    <= 4'd0;
      shadow_l_r    <= 4'd0;
      frame_start_r <= 1'b0;
    end else if (!en) begin
      state_r       <= S_GAP_HL;
      presc_r       <= '0;
      frame_start_r <= 1'b0;
    end else if (last_s) begin
      presc_r <= '0;
      state_r <= next_state(state_r);
      if (state_r == S_GAP_HL) begin
        shadow_h_r    <= qh;
        shadow_l_r    <= ql;
        frame_start_r <= 1'b1;
      end else begin
        frame_start_r <= 1'b0;
      end
    end else begin
      presc_r       <= presc_r + PRESC_ONE;
      frame_start_r <= 1'b0;
    end
  end

  // Output registers with polarity applied; reset forces them inactive immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_r <= SEG_OFF;
      dig_r <= DIG_OFF;
    end else begin
      seg_r <= seg_act_s ^ SEG_OFF;
      dig_r <= dig_act_s ^ DIG_OFF;
    end
  end

  assign seg         = seg_r;
  assign dig         = dig_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: frame-position model plus directed literal checks.
// Runs a positive-polarity instance and an inverted-polarity instance side by side.
module tb_seg_scan_driver;

  localparam int S = 4;
  localparam int G = 2;
  localparam int P = 2 * (S + G);
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic [3:0] qh = 4'd5, ql = 4'd9, qh2 = 4'd0, ql2 = 4'd7;
  logic [6:0] seg, seg2;
  logic [1:0] dig, dig2;
  logic       fs, fs2;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(S), .GAP_CYC(G), .SEG_POL(1'b0), .DIG_POL(1'b0)) dut (
    .clk(clk), .reset(reset), .qh(qh), .ql(ql), .en(en),
    .seg(seg), .dig(dig), .frame_start(fs)
  );

  seg_scan_driver #(.SCAN_DIV(S), .GAP_CYC(G), .SEG_POL(1'b1), .DIG_POL(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .qh(qh2), .ql(ql2), .en(en),
    .seg(seg2), .dig(dig2), .frame_start(fs2)
  );

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: dec = 7'h3F; 4'd1: dec = 7'h06; 4'd2: dec = 7'h5B; 4'd3: dec = 7'h4F;
      4'd4: dec = 7'h66; 4'd5: dec = 7'h6D; 4'd6: dec = 7'h7D; 4'd7: dec = 7'h07;
      4'd8: dec = 7'h7F; 4'd9: dec = 7'h6F; default: dec = 7'h40;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: position t within a frame of P cycles; HL gap, units, LH gap, tens.
  int         t;
  logic [3:0] msh [2];
  logic [3:0] msl [2];
  logic [6:0] mseg [2];
  logic [1:0] mdig [2];
  logic       mfs;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t = 0; mfs = 1'b0;
      for (int c = 0; c < 2; c++) begin
        msh[c] = 4'd0; msl[c] = 4'd0; mseg[c] = 7'h00; mdig[c] = 2'b00;
      end
    end else if (!en) begin
      t = 0; mfs = 1'b0;
      for (int c = 0; c < 2; c++) begin
        mseg[c] = 7'h00; mdig[c] = 2'b00;
      end
    end else begin
      int p;
      p = t % P;
      for (int c = 0; c < 2; c++) begin
        mseg[c] = 7'h00; mdig[c] = 2'b00;
        if (p >= G && p < G + S) begin
          mseg[c] = dec(msl[c]); mdig[c] = 2'b01;
        end else if (p >= 2 * G + S && !(LZ && msh[c] == 4'd0)) begin
          mseg[c] = dec(msh[c]); mdig[c] = 2'b10;
        end
      end
      mfs = (((t + 1) % P) == G);
      if (mfs) begin
        msh[0] = qh; msl[0] = ql; msh[1] = qh2; msl[1] = ql2;
      end
      t = t + 1;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_seg",  {1'b0, seg},  {1'b0, mseg[0]});
      chk("cyc_dig",  {6'd0, dig},  {6'd0, mdig[0]});
      chk("cyc_fs",   {7'd0, fs},   {7'd0, mfs});
      chk("cyc_seg2", {1'b0, seg2}, {1'b0, mseg[1] ^ 7'h7F});
      chk("cyc_dig2", {6'd0, dig2}, {6'd0, mdig[1] ^ 2'b11});
      chk("cyc_fs2",  {7'd0, fs2},  {7'd0, mfs});
    end
  end

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < 200);
    if (!fs) begin
      n_checks++; n_errors++;
      $display("FAIL fs_timeout actual=no_pulse required=pulse");
    end
  endtask

  initial begin
    int n;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_seg",  {1'b0, seg},  8'h00);
    chk("rst_dig",  {6'd0, dig},  8'h00);
    chk("rst_fs",   {7'd0, fs},   8'h00);
    chk("rst_seg2", {1'b0, seg2}, 8'h7F);
    chk("rst_dig2", {6'd0, dig2}, 8'h03);
    reset = 1'b1;

    // First frame: 2-cycle gap, snapshot, units then tens
    wait_fs(n);
    chk("first_fs_lat", 8'(n), 8'd2);
    @(negedge clk);
    chk("units_seg",   {1'b0, seg},  8'h6F);
    chk("units_dig",   {6'd0, dig},  8'h01);
    chk("model_units", {1'b0, mseg[0]}, 8'h6F);
    chk("units_seg2",  {1'b0, seg2}, 8'h78);
    chk("units_dig2",  {6'd0, dig2}, 8'h02);
    repeat (6) @(negedge clk);
    chk("tens_seg",  {1'b0, seg},  8'h6D);
    chk("tens_dig",  {6'd0, dig},  8'h02);
    chk("tens_seg2", {1'b0, seg2}, LZ ? 8'h7F : 8'h40);
    chk("tens_dig2", {6'd0, dig2}, LZ ? 8'h03 : 8'h01);

    // Input change mid-frame is deferred to the next snapshot
    ql = 4'd3;
    wait_fs(n);
    chk("frame_period", 8'(n + 7), 8'd12);
    @(negedge clk);
    chk("new_units_seg", {1'b0, seg}, 8'h4F);

    // Non-BCD codes show a dash on both digits
    qh = 4'hF; ql = 4'hC;
    wait_fs(n);
    @(negedge clk);
    chk("dash_lo_seg", {1'b0, seg}, 8'h40);
    repeat (6) @(negedge clk);
    chk("dash_hi_seg", {1'b0, seg}, 8'h40);
    chk("dash_hi_dig", {6'd0, dig}, 8'h02);

    // Asynchronous reset in the middle of the units phase
    wait_fs(n);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_seg",  {1'b0, seg},  8'h00);
    chk("async_dig",  {6'd0, dig},  8'h00);
    chk("async_seg2", {1'b0, seg2}, 8'h7F);
    chk("async_dig2", {6'd0, dig2}, 8'h03);
    repeat (2) @(negedge clk);
    qh = 4'd5; ql = 4'd9;
    reset = 1'b1;
    wait_fs(n);
    chk("post_rst_lat", 8'(n), 8'd2);
    @(negedge clk);
    chk("post_rst_seg", {1'b0, seg}, 8'h6F);

    // Disable for 3 clocks during the tens phase
    n = 0;
    while (dig !== 2'b10 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("find_hi", {6'd0, dig}, 8'h02);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_dig", {6'd0, dig}, 8'h00);
    chk("en_off_seg", {1'b0, seg}, 8'h00);
    repeat (2) @(negedge clk);
    en = 1'b1;
    wait_fs(n);
    chk("en_on_lat", 8'(n), 8'd2);
    @(negedge clk);
    chk("en_on_dig", {6'd0, dig}, 8'h01);

    repeat (P) @(negedge clk);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
